// File: rtl/vme_read_seq.sv
// Read-cycle sequencer for the VME64 slave register file.
// Drives the byte-mux select, waits for the mux output to settle, captures the
// selected byte and acknowledges the bus. BLT mode auto-increments the index.
module vme_read_seq #(
    parameter int unsigned NUM_REGS   = 10,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_req,
    input  logic [3:0] rd_addr,
    input  logic       blt,
    input  logic [7:0] mux_dout,
    output logic [3:0] sel,
    output logic [7:0] rd_data,
    output logic       dtack,
    output logic       addr_err,
    output logic       busy
);

    localparam logic [3:0] NumRegs   = 4'(NUM_REGS);
    localparam logic [3:0] LastIdx   = 4'(NUM_REGS - 1);
    localparam logic [2:0] SettleMax = 3'(SETTLE_CYC);

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StAck
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] index_q, index_d;
    logic       blt_mode_q, blt_mode_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] sel_q, sel_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       dtack_q, dtack_d;
    logic       addr_err_q, addr_err_d;

    // Mux select code: index i maps to 4'hF - i; out-of-range parks the mux at 0000 (reads FF).
    function automatic logic [3:0] encode_sel(input logic [3:0] idx);
        return (idx < NumRegs) ? (4'hF - idx) : 4'h0;
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        blt_mode_d = blt_mode_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        rd_data_d  = rd_data_q;
        dtack_d    = dtack_q;
        addr_err_d = addr_err_q;

        case (state_q)
            StIdle: begin
                if (rd_req) begin
                    state_d = StSelect;
                    cnt_d   = 3'd0;
                    if (!blt_mode_q) begin
                        index_d    = rd_addr;
                        blt_mode_d = blt;
                        sel_d      = encode_sel(rd_addr);
                    end else begin
                        // Mid-burst: keep the auto-incremented index, ignore rd_addr.
                        sel_d = encode_sel(index_q);
                    end
                end else if (!blt) begin
                    blt_mode_d = 1'b0;
                end
            end

            StSelect: begin
                if (!rd_req) begin
                    // Abort: no acknowledge and the index is left untouched for a retry.
                    state_d = StIdle;
                    sel_d   = 4'h0;
                end else if (cnt_q == SettleMax) begin
                    state_d    = StAck;
                    rd_data_d  = mux_dout;
                    dtack_d    = 1'b1;
                    addr_err_d = (index_q >= NumRegs);
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            StAck: begin
                if (!rd_req) begin
                    state_d    = StIdle;
                    dtack_d    = 1'b0;
                    addr_err_d = 1'b0;
                    sel_d      = 4'h0;
                    if (blt_mode_q) begin
                        // Wraps the last register to 0; an invalid start also restarts at 0.
                        index_d = (index_q >= LastIdx) ? 4'h0 : index_q + 4'h1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                sel_d   = 4'h0;
                dtack_d = 1'b0;
            end
        endcase
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            index_q    <= 4'h0;
            blt_mode_q <= 1'b0;
            cnt_q      <= 3'd0;
            sel_q      <= 4'h0;
            rd_data_q  <= 8'h00;
            dtack_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            blt_mode_q <= blt_mode_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            rd_data_q  <= rd_data_d;
            dtack_q    <= dtack_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign sel      = sel_q;
    assign rd_data  = rd_data_q;
    assign dtack    = dtack_q;
    assign addr_err = addr_err_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_vme_read_seq.sv
// Directed bench for vme_read_seq: default-settle instance behind a behavioural
// byte mux, plus a SETTLE_CYC=3 instance with a directly driven mux output.
module tb_vme_read_seq;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic       clk;
    logic       reset;

    logic       rd_req, blt;
    logic [3:0] rd_addr;
    logic [7:0] mux_dout;
    logic [3:0] sel;
    logic [7:0] rd_data;
    logic       dtack, addr_err, busy;

    logic       rd_req3, blt3;
    logic [3:0] rd_addr3;
    logic [7:0] mux3;
    logic [3:0] sel3;
    logic [7:0] rd_data3;
    logic       dtack3, addr_err3, busy3;

    logic [7:0] mem [16];
    exp_t       sb [$];
    int         errors = 0;
    int         checks = 0;

    vme_read_seq #(.NUM_REGS(10), .SETTLE_CYC(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .blt      (blt),
        .mux_dout (mux_dout),
        .sel      (sel),
        .rd_data  (rd_data),
        .dtack    (dtack),
        .addr_err (addr_err),
        .busy     (busy)
    );

    vme_read_seq #(.NUM_REGS(10), .SETTLE_CYC(3)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .rd_req   (rd_req3),
        .rd_addr  (rd_addr3),
        .blt      (blt3),
        .mux_dout (mux3),
        .sel      (sel3),
        .rd_data  (rd_data3),
        .dtack    (dtack3),
        .addr_err (addr_err3),
        .busy     (busy3)
    );

    // Byte mux model: select 0000 reads FF, otherwise register 15 - sel.
    assign mux_dout = (sel == 4'h0) ? 8'hFF : mem[4'hF - sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected capture and compare against the acknowledged data.
    task automatic sb_check(input string tag, input logic [7:0] data, input logic err);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed capture with empty scoreboard", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, data, e.data);
            check({tag, "_err"}, 8'(err), 8'(e.err));
        end
    endtask

    // One complete transfer on the S=1 instance with fixed expected timing.
    task automatic do_read(input string tag, input logic [3:0] addr, input logic b,
                           input logic [7:0] exp_data, input logic exp_err,
                           input logic [3:0] exp_sel);
        exp_t e;
        e.data = exp_data;
        e.err  = exp_err;
        rd_addr = addr;
        blt     = b;
        rd_req  = 1'b1;
        sb.push_back(e);
        tick();  // accept edge
        check({tag, "_sel_acc"}, 8'(sel), 8'(exp_sel));
        check({tag, "_busy"}, 8'(busy), 8'h01);
        check({tag, "_dtack_k"}, 8'(dtack), 8'h00);
        tick();
        check({tag, "_dtack_k1"}, 8'(dtack), 8'h00);
        tick();  // capture edge
        check({tag, "_dtack_k2"}, 8'(dtack), 8'h01);
        check({tag, "_sel_hold"}, 8'(sel), 8'(exp_sel));
        sb_check(tag, rd_data, addr_err);
        tick();
        check({tag, "_dtack_hold"}, 8'(dtack), 8'h01);
        rd_req = 1'b0;
        tick();  // release edge
        check({tag, "_dtack_rel"}, 8'(dtack), 8'h00);
        check({tag, "_err_rel"}, 8'(addr_err), 8'h00);
        check({tag, "_sel_rel"}, 8'(sel), 8'h00);
        check({tag, "_busy_rel"}, 8'(busy), 8'h00);
        tick();  // one idle clock
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = {4'(i), ~4'(i)};
        mem[3] = 8'hA5;
        mem[6] = 8'h5A;

        // Reset asserted together with a request: reset wins.
        reset = 1'b1;
        rd_req = 1'b1; rd_addr = 4'd3; blt = 1'b0;
        rd_req3 = 1'b0; rd_addr3 = 4'd0; blt3 = 1'b0; mux3 = 8'h00;
        tick(); tick(); tick();
        check("rst_sel", 8'(sel), 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_dtack", 8'(dtack), 8'h00);
        check("rst_addr_err", 8'(addr_err), 8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        rd_req = 1'b0;
        reset  = 1'b0;
        tick();
        check("post_rst_busy", 8'(busy), 8'h00);

        // Single read and an invalid index.
        do_read("single3", 4'd3, 1'b0, 8'hA5, 1'b0, 4'b1100);
        do_read("invalid12", 4'd12, 1'b0, 8'hFF, 1'b1, 4'b0000);

        // BLT burst from 8 wrapping through 9 to 0 and 1; rd_addr ignored mid-burst.
        do_read("blt8", 4'd8, 1'b1, mem[8], 1'b0, 4'b0111);
        do_read("blt9", 4'd2, 1'b1, mem[9], 1'b0, 4'b0110);
        do_read("blt0", 4'd5, 1'b1, mem[0], 1'b0, 4'b1111);
        do_read("blt1", 4'd7, 1'b1, mem[1], 1'b0, 4'b1110);
        blt = 1'b0;
        tick();
        do_read("after_blt", 4'd5, 1'b0, mem[5], 1'b0, 4'b1010);

        // Abort mid-SELECT inside a burst; the retry reuses the same index.
        do_read("blt4", 4'd4, 1'b1, mem[4], 1'b0, 4'b1011);
        rd_req = 1'b1;
        tick();
        check("abort_sel_acc", 8'(sel), 8'b1010);
        rd_req = 1'b0;
        tick();
        check("abort_busy", 8'(busy), 8'h00);
        check("abort_sel", 8'(sel), 8'h00);
        check("abort_dtack", 8'(dtack), 8'h00);
        tick();
        check("abort_dtack2", 8'(dtack), 8'h00);
        do_read("retry5", 4'd0, 1'b1, mem[5], 1'b0, 4'b1010);
        blt = 1'b0;
        tick();

        // Reset in the middle of ACK clears outputs without a clock edge.
        rd_addr = 4'd6; blt = 1'b1; rd_req = 1'b1;
        tick(); tick(); tick();
        check("mid_ack_dtack", 8'(dtack), 8'h01);
        check("mid_ack_data", rd_data, 8'h5A);
        #2 reset = 1'b1;
        #1;
        check("async_rst_dtack", 8'(dtack), 8'h00);
        check("async_rst_data", rd_data, 8'h00);
        check("async_rst_sel", 8'(sel), 8'h00);
        check("async_rst_busy", 8'(busy), 8'h00);
        #1 reset = 1'b0;
        // No idle clock in between: a stale blt_mode would ignore rd_addr here.
        do_read("post_rst2", 4'd2, 1'b0, mem[2], 1'b0, 4'b1101);

        // SETTLE_CYC=3 instance: dtack 4 clocks after accept, late mux change captured.
        rd_addr3 = 4'd3; rd_req3 = 1'b1; mux3 = 8'h11;
        tick();
        check("s3_sel_acc", 8'(sel3), 8'b1100);
        check("s3_dtack_k", 8'(dtack3), 8'h00);
        tick();
        check("s3_dtack_k1", 8'(dtack3), 8'h00);
        tick();
        check("s3_dtack_k2", 8'(dtack3), 8'h00);
        mux3 = 8'h77;
        sb.push_back('{data: 8'h77, err: 1'b0});
        tick();
        check("s3_dtack_k3", 8'(dtack3), 8'h00);
        tick();
        check("s3_dtack_k4", 8'(dtack3), 8'h01);
        sb_check("s3_capture", rd_data3, addr_err3);
        rd_req3 = 1'b0;
        tick();
        check("s3_dtack_rel", 8'(dtack3), 8'h00);
        check("s3_busy_rel", 8'(busy3), 8'h00);

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL sb_leftover: observed %0d expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
